operand_capture: RTL and testbench
==================================

# operand_capture

Downstream consumer of the keypad scanner. Turns the stream of decoded key codes into two unsigned BCD operands of `NDIGITS` digits, adds them with a digit-serial BCD adder, and presents the operand being entered, or the sum, on one display bus. Control keys are fixed: A = next operand, B = equals, C = clear.

## Interface
- `NDIGITS`, default 3: digits per operand, legal range 1–4.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `key_valid`  in  1  single-cycle strobe; one strobe per keypress.
- `key_code`  in  4  key value, sampled only when `key_valid`=1.
  - 0–9: digit.
  - 10: A.
  - 11: B.
  - 12: C.
  - 13–15: other.
- `operand_a`  out  4*NDIGITS  first operand, BCD, right-aligned.
- `operand_b`  out  4*NDIGITS  second operand, BCD, right-aligned.
- `sum`  out  4*(NDIGITS+1)  BCD sum; the top digit is the carry (0 or 1).
- `sum_valid`  out  1  high while in SHOW.
- `state_out`  out  2  current state: 0 ENTER_A, 1 ENTER_B, 2 ADD, 3 SHOW.
- `disp_value`  out  4*(NDIGITS+1)  display source.
  - ENTER_A: `operand_a`, zero-extended.
  - ENTER_B / ADD: `operand_b`, zero-extended.
  - SHOW: `sum`.
- `digit_rejected`  out  1  one-cycle pulse when a digit is dropped because the operand is full.

## Operation
- **Reset:** `rst`=1 at a clock edge forces the following, regardless of state:
  - state ENTER_A;
  - both digit counters 0;
  - all data outputs 0; `sum_valid`=0, `digit_rejected`=0;
  - the adder carry 0.
  - A reset during ADD aborts the addition; no partial sum survives.
- **Digit entry (ENTER_A / ENTER_B)**, applies to the active operand:
  - If count < NDIGITS: operand <= (operand << 4) | digit, count += 1.
  - Else: operand unchanged, `digit_rejected` pulses.
  - Leading zeros count as digits.
- **ENTER_A:**
  - A: go to ENTER_B; clear `operand_b` and its count. Valid even when zero digits have been entered (operand_a = 0).
  - B: ignored.
- **ENTER_B:**
  - A: ignored.
  - B: go to ADD; clear `sum` and the carry; digit index = 0.
- **ADD:** all keys except C are ignored. One BCD digit is processed per cycle, LSD first:
  - t = a[i] + b[i] + carry.
  - If t > 9: digit = t − 10, carry = 1; else digit = t, carry = 0.
  - At the final digit (i = NDIGITS−1), in the same cycle: `sum[top]` <= carry and state <= SHOW.
- **SHOW:**
  - Digit d: full clear, then `operand_a` = d, count_a = 1, go to ENTER_A.
  - A and B: ignored.
- **C, any state including ADD:**
  - Clears both operands, both counts, `sum` and the carry.
  - Goes to ENTER_A.
- Codes 13–15 are ignored unless the configuration feature below is compiled in.
- The operand registers never hold non-BCD digits; inputs are 0–9 by construction.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **Entry latency:** a key sampled at edge E updates the operand, count, state and `disp_value` as visible after edge E.
- **Addition latency:** B sampled at edge E0.
  - `state_out`=2 after E0.
  - Digit i is written at edge E0+1+i.
  - `sum_valid`=1 and the full `sum` are visible after edge E0+NDIGITS; with NDIGITS=3, that is 3 cycles after the B edge.
- **`digit_rejected`:** high for exactly the one cycle following the edge that sampled the rejected digit.
- **`key_valid` held high:** every cycle it is high counts as a separate keypress. The upstream block must produce exactly one strobe per press.
- **Simultaneous events:**
  - `rst` has priority over any key.
  - C has priority over ADD progression in the same cycle.

## Configuration
- `DIGIT_DELETE_EN` defined:
  - Code 13 (D) in ENTER_A / ENTER_B: active operand <= operand >> 4, count −= 1.
  - No effect when count is 0.
  - Ignored in ADD and SHOW.
- `DIGIT_DELETE_EN` undefined: code 13 is ignored in every state, and no delete logic is synthesized.

## Test plan
- **Basic add:** keys 1,2,3,A,4,5,B.
  - `operand_a`=0x123, `operand_b`=0x045.
  - Exactly 3 cycles after the B edge: `sum_valid`=1, `sum`=0x0168, `disp_value`=0x0168.
- **Max carry:** 9,9,9,A,9,9,9,B → `sum`=0x1998.
- **Overflow:** keys 1,2,3,4 → `operand_a`=0x123, with a single `digit_rejected` pulse on the 4th key.
- **Abort:** C strobed one cycle after B, during ADD → state 0, all operands and `sum` = 0, `sum_valid` never rises. The same check applies with `rst` asserted instead of C.
- **Restart from SHOW:** after 0x0168 is shown, key 7 → state 0, `operand_a`=0x007, `sum`=0, `sum_valid`=0.
- **Delete** (only with `DIGIT_DELETE_EN`):
  - 5,6,D → `operand_a`=0x005, count 1.
  - D,D on an empty operand → stays 0.
  - Without the macro, 5,6,D → `operand_a`=0x056.

Source files
------------

// File: rtl/operand_capture.sv
// operand_capture: collects two NDIGITS-digit BCD operands from decoded key
// codes, adds them digit-serially (LSD first) and drives a display bus with
// the operand being entered or the sum.
// Control keys: 10 = A (next operand), 11 = B (equals), 12 = C (clear).
// Optional feature macro: DIGIT_DELETE_EN (code 13 deletes the last digit).
module operand_capture #(
  parameter int NDIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic [4*NDIGITS-1:0]     operand_a,
  output logic [4*NDIGITS-1:0]     operand_b,
  output logic [4*(NDIGITS+1)-1:0] sum,
  output logic                     sum_valid,
  output logic [1:0]               state_out,
  output logic [4*(NDIGITS+1)-1:0] disp_value,
  output logic                     digit_rejected
);

  localparam int W  = 4 * NDIGITS;
  localparam int SW = 4 * (NDIGITS + 1);
  localparam logic [2:0] ND   = 3'(NDIGITS);
  localparam logic [1:0] LAST = 2'(NDIGITS - 1);

  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
`ifdef DIGIT_DELETE_EN
  localparam logic [3:0] KEY_D = 4'd13;
`endif

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ADD     = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  opa, opa_n, opb, opb_n;
  logic [SW-1:0] sum_r, sum_n;
  logic [2:0]    cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic          carry, carry_n;
  logic [1:0]    idx, idx_n;
  logic          rej_n, sv_n;
  logic [SW-1:0] disp_n;

  logic          is_digit;
  logic [3:0]    ad, bd, dig;
  logic [4:0]    t;
  logic          cy;

  // State and datapath registers; disp_value/sum_valid are registered copies
  // derived from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ENTER_A;
      opa            <= '0;
      opb            <= '0;
      sum_r          <= '0;
      cnt_a          <= '0;
      cnt_b          <= '0;
      carry          <= 1'b0;
      idx            <= '0;
      digit_rejected <= 1'b0;
      sum_valid      <= 1'b0;
      disp_value     <= '0;
    end else begin
      state          <= state_n;
      opa            <= opa_n;
      opb            <= opb_n;
      sum_r          <= sum_n;
      cnt_a          <= cnt_a_n;
      cnt_b          <= cnt_b_n;
      carry          <= carry_n;
      idx            <= idx_n;
      digit_rejected <= rej_n;
      sum_valid      <= sv_n;
      disp_value     <= disp_n;
    end
  end

  // Next-state, key handling and one digit of BCD addition per cycle.
  always_comb begin
    state_n  = state;
    opa_n    = opa;
    opb_n    = opb;
    sum_n    = sum_r;
    cnt_a_n  = cnt_a;
    cnt_b_n  = cnt_b;
    carry_n  = carry;
    idx_n    = idx;
    rej_n    = 1'b0;
    is_digit = (key_code <= 4'd9);

    // Current digit pair for the adder.
    ad = '0;
    bd = '0;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if (2'(k) == idx) begin
        ad = opa[4*k +: 4];
        bd = opb[4*k +: 4];
      end
    end
    t = {1'b0, ad} + {1'b0, bd} + {4'd0, carry};
    if (t > 5'd9) begin
      dig = 4'(t - 5'd10);
      cy  = 1'b1;
    end else begin
      dig = t[3:0];
      cy  = 1'b0;
    end

    if (key_valid && key_code == KEY_C) begin
      // Clear wins over everything, including an addition in progress.
      state_n = ENTER_A;
      opa_n   = '0;
      opb_n   = '0;
      sum_n   = '0;
      cnt_a_n = '0;
      cnt_b_n = '0;
      carry_n = 1'b0;
      idx_n   = '0;
    end else begin
      case (state)
        ENTER_A: begin
          if (key_valid) begin
            if (is_digit) begin
              if (cnt_a < ND) begin
                opa_n   = (opa << 4) | W'(key_code);
                cnt_a_n = cnt_a + 3'd1;
              end else begin
                rej_n = 1'b1;
              end
            end else if (key_code == KEY_A) begin
              state_n = ENTER_B;
              opb_n   = '0;
              cnt_b_n = '0;
            end
`ifdef DIGIT_DELETE_EN
            else if (key_code == KEY_D && cnt_a != 3'd0) begin
              opa_n   = opa >> 4;
              cnt_a_n = cnt_a - 3'd1;
            end
`endif
          end
        end
        ENTER_B: begin
          if (key_valid) begin
            if (is_digit) begin
              if (cnt_b < ND) begin
                opb_n   = (opb << 4) | W'(key_code);
                cnt_b_n = cnt_b + 3'd1;
              end else begin
                rej_n = 1'b1;
              end
            end else if (key_code == KEY_B) begin
              state_n = ADD;
              sum_n   = '0;
              carry_n = 1'b0;
              idx_n   = '0;
            end
`ifdef DIGIT_DELETE_EN
            else if (key_code == KEY_D && cnt_b != 3'd0) begin
              opb_n   = opb >> 4;
              cnt_b_n = cnt_b - 3'd1;
            end
`endif
          end
        end
        ADD: begin
          for (int unsigned k = 0; k < NDIGITS; k++) begin
            if (2'(k) == idx) sum_n[4*k +: 4] = dig;
          end
          carry_n = cy;
          if (idx == LAST) begin
            // Final digit: the carry out lands in the top sum digit in the same cycle.
            sum_n[SW-1 -: 4] = {3'b000, cy};
            state_n          = SHOW;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
        SHOW: begin
          if (key_valid && is_digit) begin
            state_n = ENTER_A;
            opa_n   = W'(key_code);
            opb_n   = '0;
            sum_n   = '0;
            cnt_a_n = 3'd1;
            cnt_b_n = '0;
            carry_n = 1'b0;
            idx_n   = '0;
          end
        end
        default: state_n = ENTER_A;
      endcase
    end

    sv_n = (state_n == SHOW);
    case (state_n)
      ENTER_A: disp_n = SW'(opa_n);
      ENTER_B: disp_n = SW'(opb_n);
      ADD:     disp_n = SW'(opb_n);
      default: disp_n = sum_n;
    endcase
  end

  assign operand_a = opa;
  assign operand_b = opb;
  assign sum       = sum_r;
  assign state_out = state;

endmodule

// File: tb/tb_operand_capture.sv
// Self-checking bench for operand_capture (NDIGITS = 3).
module tb_operand_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [11:0] operand_a, operand_b;
  logic [15:0] sum, disp_value;
  logic        sum_valid, digit_rejected;
  logic [1:0]  state_out;

  operand_capture #(.NDIGITS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .sum            (sum),
    .sum_valid      (sum_valid),
    .state_out      (state_out),
    .disp_value     (disp_value),
    .digit_rejected (digit_rejected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    int          idle;
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] s;
    logic [1:0]  st;
    logic [15:0] disp;
    logic        rej;
    logic        sv;
  } vec_t;

  vec_t        tbl[17];
  vec_t        exp_q[$];
  logic [15:0] sum_q[$];
  int          nchk = 0;
  int          nerr = 0;

  function automatic vec_t mk(input logic [3:0] code, input int idle,
                              input logic [11:0] a, input logic [11:0] b,
                              input logic [15:0] s, input logic [1:0] st,
                              input logic [15:0] disp, input logic rej,
                              input logic sv);
    vec_t v;
    v.code = code; v.idle = idle; v.a = a; v.b = b; v.s = s;
    v.st = st; v.disp = disp; v.rej = rej; v.sv = sv;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic key(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply(input int n, input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    key(v.code);
    repeat (v.idle) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("v%0d.operand_a", n), 32'(operand_a), 32'(e.a));
    check($sformatf("v%0d.operand_b", n), 32'(operand_b), 32'(e.b));
    check($sformatf("v%0d.sum", n), 32'(sum), 32'(e.s));
    check($sformatf("v%0d.state", n), 32'(state_out), 32'(e.st));
    check($sformatf("v%0d.disp", n), 32'(disp_value), 32'(e.disp));
    check($sformatf("v%0d.rejected", n), 32'(digit_rejected), 32'(e.rej));
    check($sformatf("v%0d.sum_valid", n), 32'(sum_valid), 32'(e.sv));
  endtask

  task automatic check_cleared(input string nm);
    check({nm, ".state"}, 32'(state_out), 32'd0);
    check({nm, ".operand_a"}, 32'(operand_a), 32'd0);
    check({nm, ".operand_b"}, 32'(operand_b), 32'd0);
    check({nm, ".sum"}, 32'(sum), 32'd0);
    check({nm, ".disp"}, 32'(disp_value), 32'd0);
  endtask

  // Enter a, b then press B; returns just after the B edge.
  task automatic enter_pair(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0,
                            input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0);
    key(a2); key(a1); key(a0); key(4'd10);
    key(b2); key(b1); key(b0); key(4'd11);
  endtask

  // Wait (bounded) for sum_valid, compare cycle count and popped sum.
  task automatic wait_sum(input string nm, input int exp_cycles);
    int cyc;
    logic [15:0] e;
    cyc = 0;
    while (!sum_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, ".latency"}, 32'(cyc), 32'(exp_cycles));
    e = (sum_q.size() > 0) ? sum_q.pop_front() : 16'hxxxx;
    check({nm, ".sum"}, 32'(sum), 32'(e));
    check({nm, ".disp"}, 32'(disp_value), 32'(e));
  endtask

  task automatic watch_no_sv(input string nm);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (sum_valid) seen = 1'b1;
    end
    check({nm, ".sum_valid_seen"}, 32'(seen), 32'd0);
  endtask

  initial begin
    //              code  idle a       b       sum      st    disp     rej   sv
    tbl[0]  = mk(4'd1,  0, 12'h001, 12'h000, 16'h0000, 2'd0, 16'h0001, 1'b0, 1'b0);
    tbl[1]  = mk(4'd2,  0, 12'h012, 12'h000, 16'h0000, 2'd0, 16'h0012, 1'b0, 1'b0);
    tbl[2]  = mk(4'd3,  0, 12'h123, 12'h000, 16'h0000, 2'd0, 16'h0123, 1'b0, 1'b0);
    tbl[3]  = mk(4'd4,  0, 12'h123, 12'h000, 16'h0000, 2'd0, 16'h0123, 1'b1, 1'b0);
    tbl[4]  = mk(4'd11, 0, 12'h123, 12'h000, 16'h0000, 2'd0, 16'h0123, 1'b0, 1'b0);
    tbl[5]  = mk(4'd15, 0, 12'h123, 12'h000, 16'h0000, 2'd0, 16'h0123, 1'b0, 1'b0);
    tbl[6]  = mk(4'd10, 0, 12'h123, 12'h000, 16'h0000, 2'd1, 16'h0000, 1'b0, 1'b0);
    tbl[7]  = mk(4'd10, 0, 12'h123, 12'h000, 16'h0000, 2'd1, 16'h0000, 1'b0, 1'b0);
    tbl[8]  = mk(4'd4,  0, 12'h123, 12'h004, 16'h0000, 2'd1, 16'h0004, 1'b0, 1'b0);
    tbl[9]  = mk(4'd5,  0, 12'h123, 12'h045, 16'h0000, 2'd1, 16'h0045, 1'b0, 1'b0);
    tbl[10] = mk(4'd11, 3, 12'h123, 12'h045, 16'h0168, 2'd3, 16'h0168, 1'b0, 1'b1);
    tbl[11] = mk(4'd10, 0, 12'h123, 12'h045, 16'h0168, 2'd3, 16'h0168, 1'b0, 1'b1);
    tbl[12] = mk(4'd7,  0, 12'h007, 12'h000, 16'h0000, 2'd0, 16'h0007, 1'b0, 1'b0);
    tbl[13] = mk(4'd10, 0, 12'h007, 12'h000, 16'h0000, 2'd1, 16'h0000, 1'b0, 1'b0);
    tbl[14] = mk(4'd9,  0, 12'h007, 12'h009, 16'h0000, 2'd1, 16'h0009, 1'b0, 1'b0);
    tbl[15] = mk(4'd11, 3, 12'h007, 12'h009, 16'h0016, 2'd3, 16'h0016, 1'b0, 1'b1);
    tbl[16] = mk(4'd12, 0, 12'h000, 12'h000, 16'h0000, 2'd0, 16'h0000, 1'b0, 1'b0);

    do_reset();
    check_cleared("reset");
    check("reset.sum_valid", 32'(sum_valid), 32'd0);
    check("reset.rejected", 32'(digit_rejected), 32'd0);

    for (int i = 0; i < 17; i++) apply(i, tbl[i]);

    // Basic add: exact latency of the digit-serial adder.
    do_reset();
    enter_pair(4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd5);
    sum_q.push_back(16'h0168);
    check("basic.state_add", 32'(state_out), 32'd2);
    check("basic.sv_early", 32'(sum_valid), 32'd0);
    wait_sum("basic", 3);
    check("basic.state_show", 32'(state_out), 32'd3);

    // Max carry.
    key(4'd12);
    enter_pair(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    sum_q.push_back(16'h1998);
    wait_sum("maxcarry", 3);

    // Abort with C one cycle after B.
    key(4'd12);
    enter_pair(4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd5);
    key(4'd12);
    check_cleared("abort_c");
    watch_no_sv("abort_c");
    check_cleared("abort_c_later");

    // Abort with reset one cycle after B.
    enter_pair(4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd5);
    do_reset();
    check_cleared("abort_rst");
    watch_no_sv("abort_rst");

    // Digit delete (behaviour depends on build).
    key(4'd5); key(4'd6); key(4'd13);
`ifdef DIGIT_DELETE_EN
    check("delete.operand_a", 32'(operand_a), 32'h005);
    key(4'd8);
    check("delete.count_one", 32'(operand_a), 32'h058);
    key(4'd12);
    key(4'd13); key(4'd13);
    check("delete.empty", 32'(operand_a), 32'h000);
    key(4'd3);
    check("delete.empty_count", 32'(operand_a), 32'h003);
`else
    check("delete.ignored", 32'(operand_a), 32'h056);
    check("delete.state", 32'(state_out), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
